// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes and
// the mux/ALU select codes that make up the control word.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11,
    S_ORIEX   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  function automatic logic is_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_ADDI) || (op == OP_ORI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Moore output decode: registered state (plus zero for the branch) to the
// raw control word, before fetch-hold and reset gating.
module mc_ctrl_decode
  import multicycle_pkg::*;
(
  input  logic [3:0] state,
  input  logic       zero,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic       pc_en,
  output logic       ext_zero,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src
);

  always_comb begin
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    pc_en      = 1'b0;
    ext_zero   = 1'b0;
    alu_src_b  = SRCB_REGB;
    alu_op     = ALU_ADD;
    pc_src     = PC_ALU;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = SRCB_FOUR;
        pc_en     = 1'b1;
      end
      // Branch target is precomputed here while the opcode is decoded
      S_DECODE:  alu_src_b = SRCB_IMM_SH2;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_RTYPEEX: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BEQEX: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PC_ALUOUT;
        pc_en     = zero;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_ORIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_OR;
        ext_zero  = 1'b1;
      end
      S_IMMWB:   reg_write = 1'b1;
      S_JUMP: begin
        pc_src = PC_JUMP;
        pc_en  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control FSM: state register and sequencing here,
// control word decode in mc_ctrl_decode, strobes gated by fetch-hold and reset.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic       pc_en,
  output logic       ext_zero,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       illegal,
  output logic [3:0] state
);

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic       w_ready;
  logic       w_fetch_hold;

  logic       w_iord, w_mem_read, w_mem_write, w_ir_write, w_reg_dst;
  logic       w_mem_to_reg, w_reg_write, w_alu_src_a, w_pc_en, w_ext_zero;
  logic [1:0] w_alu_src_b, w_alu_op, w_pc_src;

  assign w_ready      = mem_ready | ~MEM_WAIT_EN;
  assign w_fetch_hold = (r_state == S_FETCH) && !w_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = w_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     w_next = S_RTYPEEX;
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_BEQ:       w_next = S_BEQEX;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_ORI:       w_next = S_ORIEX;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR:  w_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   w_next = w_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   w_next = w_ready ? S_FETCH : S_MEMWR;
      S_RTYPEEX: w_next = S_ALUWB;
      S_ADDIEX:  w_next = S_IMMWB;
      S_ORIEX:   w_next = S_IMMWB;
      default:   w_next = S_FETCH;
    endcase
  end

  mc_ctrl_decode u_dec (
    .state      (r_state),
    .zero       (zero),
    .iord       (w_iord),
    .mem_read   (w_mem_read),
    .mem_write  (w_mem_write),
    .ir_write   (w_ir_write),
    .reg_dst    (w_reg_dst),
    .mem_to_reg (w_mem_to_reg),
    .reg_write  (w_reg_write),
    .alu_src_a  (w_alu_src_a),
    .pc_en      (w_pc_en),
    .ext_zero   (w_ext_zero),
    .alu_src_b  (w_alu_src_b),
    .alu_op     (w_alu_op),
    .pc_src     (w_pc_src)
  );

  // Strobes are killed during reset so an aborted access never commits
  always_comb begin
    iord       = w_iord;
    reg_dst    = w_reg_dst;
    mem_to_reg = w_mem_to_reg;
    alu_src_a  = w_alu_src_a;
    ext_zero   = w_ext_zero;
    alu_src_b  = w_alu_src_b;
    alu_op     = w_alu_op;
    pc_src     = w_pc_src;
    mem_read   = w_mem_read  & rst_n;
    mem_write  = w_mem_write & rst_n;
    reg_write  = w_reg_write & rst_n;
    ir_write   = w_ir_write  & rst_n & ~w_fetch_hold;
    pc_en      = w_pc_en     & rst_n & ~w_fetch_hold;
    illegal    = rst_n & (r_state == S_DECODE) & ~is_legal(opcode);
    state      = r_state;
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: reset abort, per-instruction state
// sequences, memory waits, illegal opcode and immediate-extension selects.
module tb_multicycle_control;

  logic       clk, rst_n, zero, mem_ready;
  logic [5:0] opcode;
  logic       iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg;
  logic       reg_write, alu_src_a, pc_en, ext_zero, illegal;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;

  int n_pass  = 0;
  int n_total = 0;

  multicycle_control #(.MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .pc_en(pc_en), .ext_zero(ext_zero),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .illegal(illegal), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'b000000; zero = 1'b0;
    tick(); tick();
    n_total++;
    if ({state, mem_read, ir_write, pc_en} !== {4'd0, 3'b000})
      $display("FAIL reset_hold: got st=%0d rd=%b irw=%b pc=%b want st=0 strobes 0", state, mem_read, ir_write, pc_en);
    else n_pass++;
    rst_n = 1'b1; #1;
    n_total++;
    if ({state, mem_read} !== {4'd0, 1'b1})
      $display("FAIL reset_release: got st=%0d rd=%b want st=0 rd=1", state, mem_read);
    else n_pass++;
    opcode = 6'b101011;
    tick(); tick(); tick();
    mem_ready = 1'b0; #1;
    n_total++;
    if ({state, mem_write} !== {4'd5, 1'b1})
      $display("FAIL reset_pre_memwr: got st=%0d wr=%b want st=5 wr=1", state, mem_write);
    else n_pass++;
    rst_n = 1'b0; #1;
    n_total++;
    if (mem_write !== 1'b0)
      $display("FAIL reset_kill_write: got wr=%b want 0", mem_write);
    else n_pass++;
    tick(); tick();
    n_total++;
    if ({state, mem_write, mem_read} !== {4'd0, 2'b00})
      $display("FAIL reset_abort: got st=%0d wr=%b rd=%b want st=0 wr=0 rd=0", state, mem_write, mem_read);
    else n_pass++;
    mem_ready = 1'b1; rst_n = 1'b1; #1;
    n_total++;
    if ({state, mem_read} !== {4'd0, 1'b1})
      $display("FAIL reset_restart: got st=%0d rd=%b want st=0 rd=1", state, mem_read);
    else n_pass++;
  endtask

  task automatic test_fetch_hold_jump();
    mem_ready = 1'b0; opcode = 6'b000010; #1;
    n_total++;
    if ({state, mem_read, ir_write, pc_en} !== {4'd0, 3'b100})
      $display("FAIL fetch_hold: got st=%0d rd=%b irw=%b pc=%b want 0 1 0 0", state, mem_read, ir_write, pc_en);
    else n_pass++;
    tick();
    n_total++;
    if (state !== 4'd0) $display("FAIL fetch_stay: got st=%0d want 0", state);
    else n_pass++;
    mem_ready = 1'b1; #1;
    n_total++;
    if ({ir_write, pc_en, alu_src_b} !== {2'b11, 2'b01})
      $display("FAIL fetch_ready: got irw=%b pc=%b srcb=%b want 1 1 01", ir_write, pc_en, alu_src_b);
    else n_pass++;
    tick();
    n_total++;
    if ({state, alu_src_b, alu_src_a} !== {4'd1, 2'b11, 1'b0})
      $display("FAIL decode_ctl: got st=%0d srcb=%b srca=%b want 1 11 0", state, alu_src_b, alu_src_a);
    else n_pass++;
    tick();
    n_total++;
    if ({state, pc_src, pc_en} !== {4'd11, 2'b10, 1'b1})
      $display("FAIL jump_ctl: got st=%0d pcsrc=%b pc=%b want 11 10 1", state, pc_src, pc_en);
    else n_pass++;
    tick();
    n_total++;
    if (state !== 4'd0) $display("FAIL jump_latency: got st=%0d want 0", state);
    else n_pass++;
  endtask

  task automatic test_lw();
    logic [3:0] exp_st [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    opcode = 6'b100011; mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n_total++;
      if ({state, reg_write, mem_to_reg} !== {exp_st[i], exp_st[i] == 4'd4, exp_st[i] == 4'd4})
        $display("FAIL lw_step%0d: got st=%0d rw=%b m2r=%b want st=%0d", i, state, reg_write, mem_to_reg, exp_st[i]);
      else n_pass++;
      if (i == 3) begin
        n_total++;
        if ({iord, mem_read} !== 2'b11)
          $display("FAIL lw_memrd: got iord=%b rd=%b want 1 1", iord, mem_read);
        else n_pass++;
      end
      if (i < 5) tick();
    end
  endtask

  task automatic test_beq();
    for (int z = 1; z >= 0; z--) begin
      opcode = 6'b000100; zero = z[0];
      tick(); tick();
      n_total++;
      if ({state, pc_en, pc_src, alu_op} !== {4'd8, z[0], 2'b01, 2'b01})
        $display("FAIL beq_z%0d: got st=%0d pc=%b pcsrc=%b op=%b want 8 %0d 01 01", z, state, pc_en, pc_src, alu_op, z);
      else n_pass++;
      tick();
      n_total++;
      if (state !== 4'd0) $display("FAIL beq_latency_z%0d: got st=%0d want 0", z, state);
      else n_pass++;
    end
    zero = 1'b0;
  endtask

  task automatic test_sw_wait();
    opcode = 6'b101011; mem_ready = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1'b1;
      #1;
      n_total++;
      if ({state, mem_write, iord} !== {4'd5, 2'b11})
        $display("FAIL sw_hold%0d: got st=%0d wr=%b iord=%b want 5 1 1", i, state, mem_write, iord);
      else n_pass++;
      tick();
    end
    n_total++;
    if ({state, mem_write} !== {4'd0, 1'b0})
      $display("FAIL sw_done: got st=%0d wr=%b want 0 0", state, mem_write);
    else n_pass++;
  endtask

  task automatic test_illegal();
    opcode = 6'b111111; mem_ready = 1'b1;
    n_total++;
    if (illegal !== 1'b0) $display("FAIL illegal_in_fetch: got %b want 0", illegal);
    else n_pass++;
    tick();
    n_total++;
    if ({state, illegal, reg_write, mem_write} !== {4'd1, 3'b100})
      $display("FAIL illegal_pulse: got st=%0d ill=%b rw=%b wr=%b want 1 1 0 0", state, illegal, reg_write, mem_write);
    else n_pass++;
    tick();
    n_total++;
    if ({state, illegal, reg_write, mem_write} !== {4'd0, 3'b000})
      $display("FAIL illegal_after: got st=%0d ill=%b rw=%b wr=%b want 0 0 0 0", state, illegal, reg_write, mem_write);
    else n_pass++;
  endtask

  task automatic test_rtype();
    opcode = 6'b000000;
    tick(); tick();
    n_total++;
    if ({state, alu_op, alu_src_a, alu_src_b} !== {4'd6, 2'b10, 1'b1, 2'b00})
      $display("FAIL rtype_ex: got st=%0d op=%b srca=%b srcb=%b want 6 10 1 00", state, alu_op, alu_src_a, alu_src_b);
    else n_pass++;
    tick();
    n_total++;
    if ({state, reg_write, reg_dst, mem_to_reg} !== {4'd7, 3'b110})
      $display("FAIL rtype_wb: got st=%0d rw=%b dst=%b m2r=%b want 7 1 1 0", state, reg_write, reg_dst, mem_to_reg);
    else n_pass++;
    tick();
    n_total++;
    if (state !== 4'd0) $display("FAIL rtype_latency: got st=%0d want 0", state);
    else n_pass++;
  endtask

  task automatic test_imm();
    logic [5:0] ops   [2] = '{6'b001101, 6'b001000};
    logic [3:0] ex_st [2] = '{4'd12, 4'd9};
    logic [1:0] ex_op [2] = '{2'b11, 2'b00};
    logic       ex_ez [2] = '{1'b1, 1'b0};
    for (int i = 0; i < 2; i++) begin
      opcode = ops[i];
      tick(); tick();
      n_total++;
      if ({state, ext_zero, alu_op, alu_src_b, alu_src_a} !== {ex_st[i], ex_ez[i], ex_op[i], 2'b10, 1'b1})
        $display("FAIL imm_ex%0d: got st=%0d ez=%b op=%b srcb=%b want st=%0d ez=%b op=%b srcb=10",
                 i, state, ext_zero, alu_op, alu_src_b, ex_st[i], ex_ez[i], ex_op[i]);
      else n_pass++;
      tick();
      n_total++;
      if ({state, reg_write, reg_dst, mem_to_reg, ext_zero} !== {4'd10, 4'b1000})
        $display("FAIL imm_wb%0d: got st=%0d rw=%b dst=%b m2r=%b ez=%b want 10 1 0 0 0", i, state, reg_write, reg_dst, mem_to_reg, ext_zero);
      else n_pass++;
      tick();
      n_total++;
      if (state !== 4'd0) $display("FAIL imm_latency%0d: got st=%0d want 0", i, state);
      else n_pass++;
    end
  endtask

  initial begin
    rst_n = 1'b0; opcode = 6'd0; zero = 1'b0; mem_ready = 1'b1;
    test_reset();
    test_fetch_hold_jump();
    test_lw();
    test_beq();
    test_sw_wait();
    test_illegal();
    test_rtype();
    test_imm();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
